// File: rtl/serial_sub.sv
// ---------------------------------------------------------------------------
// serial_sub : bit-serial WIDTH-bit subtractor (a - b, LSB first, one bit/clk)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic            borrow_ff;
  logic [CW-1:0]   cnt;
  logic            d_bit, b_out;

  // Full-subtractor cell on the current LSB pair.
  assign d_bit = sh_a[0] ^ sh_b[0] ^ borrow_ff;
  assign b_out = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & borrow_ff);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_a      <= '0;
      sh_b      <= '0;
      borrow_ff <= 1'b0;
      cnt       <= '0;
      diff      <= '0;
      borr      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a      <= a;
            sh_b      <= b;
            borrow_ff <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            borr      <= 1'b0;
          end
        end
        SHIFT: begin
          sh_a      <= sh_a >> 1;
          sh_b      <= sh_b >> 1;
          diff      <= {d_bit, diff[WIDTH-1:1]};
          borrow_ff <= b_out;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST) borr <= b_out;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
